shifter16_al_seq: RTL and testbench

Sequential 16-bit arithmetic shift-left unit, the left-direction counterpart of the combinational arithmetic shift-right barrel shifter in the CPU datapath. It accepts an operand and a 4-bit shift amount on a start handshake and shifts one bit per clock. It reports completion with a one-cycle done pulse, a sticky signed-overflow flag and a zero flag. It sits beside the ALU and serves multi-cycle SAL instructions, where area matters more than single-cycle latency.

---
 rtl/shifter16_al_seq_if.sv | 22 ++
 rtl/shifter16_al_seq.sv | 86 ++++++++
 tb/tb_shifter16_al_seq.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/shifter16_al_seq_if.sv
// Request/result bundle of the sequential 16-bit arithmetic shift-left unit.
// The requester drives start/shift/in; the unit returns result and status flags.
interface shifter16_al_seq_if;
  logic        start;
  logic [3:0]  shift;
  logic [15:0] in;
  logic [15:0] out;
  logic        busy;
  logic        done;
  logic        ovf;
  logic        zero;

  modport master (
    output start, shift, in,
    input  out, busy, done, ovf, zero
  );

  modport slave (
    input  start, shift, in,
    output out, busy, done, ovf, zero
  );
endinterface

// File: rtl/shifter16_al_seq.sv
// Sequential 16-bit arithmetic shift-left: one bit per clock, done pulse on completion,
// sticky signed-overflow and zero flags on the held result.
module shifter16_al_seq (
  input  logic              clk,
  input  logic              reset_n,
  shifter16_al_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] work_q, work_d;
  logic [15:0] out_q, out_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ovf_acc_q, ovf_acc_d;
  logic        ovf_q, ovf_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      work_q    <= 16'h0000;
      out_q     <= 16'h0000;
      cnt_q     <= 4'd0;
      ovf_acc_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      out_q     <= out_d;
      cnt_q     <= cnt_d;
      ovf_acc_q <= ovf_acc_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    out_d     = out_q;
    cnt_d     = cnt_q;
    ovf_acc_d = ovf_acc_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          work_d    = bus.in;
          cnt_d     = bus.shift;
          ovf_acc_d = 1'b0;
          if (bus.shift == 4'd0) begin
            out_d   = bus.in;
            ovf_d   = 1'b0;
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // A sign change between the top two bits means a bit leaving the word
        // disagrees with the sign that will remain.
        work_d    = {work_q[14:0], 1'b0};
        ovf_acc_d = ovf_acc_q | (work_q[15] ^ work_q[14]);
        cnt_d     = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          out_d   = work_d;
          ovf_d   = ovf_acc_d;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.out  = out_q;
  assign bus.busy = (state_q == SHIFT);
  assign bus.done = (state_q == DONE);
  assign bus.ovf  = ovf_q;
  assign bus.zero = (out_q == 16'h0000);

endmodule

// File: tb/tb_shifter16_al_seq.sv
// Randomized and directed bench for shifter16_al_seq against an edge-count-based
// reference model; outputs are compared on every falling edge.
module tb_shifter16_al_seq;

  logic clk;
  logic reset_n;
  shifter16_al_seq_if bus ();

  shifter16_al_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: operations scheduled by edge number, result from plain arithmetic.
  int          edge_no   = 0;
  bit          check_en  = 0;
  bit          m_busy    = 0;
  bit          m_done    = 0;
  logic [15:0] m_out     = 16'h0;
  bit          m_ovf     = 0;
  int          m_end     = 0;
  logic [15:0] pend_out;
  bit          pend_ovf;

  function automatic void ref_op(input logic [15:0] a, input int n,
                                 output logic [15:0] r, output bit v);
    longint p;
    p = longint'($signed(a)) * (longint'(1) << n);
    r = 16'(p);
    v = (p > 32767) || (p < -32768);
  endfunction

  always @(posedge clk) begin
    edge_no++;
    if (!reset_n) begin
      m_busy = 0; m_done = 0; m_out = 16'h0; m_ovf = 0;
    end else if (m_busy) begin
      if (edge_no == m_end) begin
        m_busy = 0; m_done = 1; m_out = pend_out; m_ovf = pend_ovf;
      end
    end else begin
      m_done = 0;
      if (bus.start) begin
        ref_op(bus.in, int'(bus.shift), pend_out, pend_ovf);
        if (bus.shift == 4'd0) begin
          m_done = 1; m_out = pend_out; m_ovf = 0;
        end else begin
          m_busy = 1; m_end = edge_no + int'(bus.shift);
        end
      end
    end
    check_en = 1;
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("busy", {15'h0, bus.busy}, {15'h0, m_busy});
      chk("done", {15'h0, bus.done}, {15'h0, m_done});
      chk("out",  bus.out, m_out);
      chk("ovf",  {15'h0, bus.ovf},  {15'h0, m_ovf});
      chk("zero", {15'h0, bus.zero}, {15'h0, (m_out == 16'h0)});
    end
  end

  task automatic drive(input bit s, input logic [15:0] a, input logic [3:0] n);
    @(posedge clk); #1;
    bus.start = s; bus.in = a; bus.shift = n;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 24 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL %s: done never seen within 24 cycles", name);
    end
  endtask

  task automatic run_op(input string name, input logic [15:0] a, input logic [3:0] n,
                        input bit lit, input logic [15:0] exp_out, input bit exp_ovf);
    drive(1'b1, a, n);
    drive(1'b0, 16'h0, 4'd0);
    wait_done(name);
    if (lit) begin
      chk({name, "_out"}, bus.out, exp_out);
      chk({name, "_ovf"}, {15'h0, bus.ovf}, {15'h0, exp_ovf});
      chk({name, "_model"}, m_out, exp_out);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    bus.start = 1'b0; bus.in = 16'h0; bus.shift = 4'd0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("reset_zero", {15'h0, bus.zero}, 16'h1);
    chk("reset_out", bus.out, 16'h0);

    // Busy length check on the basic case: count busy cycles and done position.
    begin
      int busy_cycles;
      busy_cycles = 0;
      drive(1'b1, 16'h0003, 4'd4);
      drive(1'b0, 16'h0, 4'd0);
      for (int i = 0; i < 24 && !bus.done; i++) begin
        @(negedge clk);
        if (bus.busy) busy_cycles++;
      end
      chk("basic_busy_cycles", 16'(busy_cycles), 16'd4);
      chk("basic_out", bus.out, 16'h0030);
      chk("basic_ovf", {15'h0, bus.ovf}, 16'h0);
      chk("basic_zero", {15'h0, bus.zero}, 16'h0);
    end

    run_op("zero_shift", 16'h8001, 4'd0, 1, 16'h8001, 0);
    run_op("ovf_4000",   16'h4000, 4'd1, 1, 16'h8000, 1);
    run_op("c000",       16'hC000, 4'd1, 1, 16'h8000, 0);
    run_op("ffff_15",    16'hFFFF, 4'd15, 1, 16'h8000, 0);
    run_op("one_15",     16'h0001, 4'd15, 1, 16'h8000, 1);
    run_op("out_8000",   16'h8000, 4'd1, 1, 16'h0000, 1);
    chk("out_8000_zero", {15'h0, bus.zero}, 16'h1);

    // Reset mid-shift with start held high during reset.
    drive(1'b1, 16'h1234, 4'd8);
    drive(1'b0, 16'h0, 4'd0);
    drive(1'b0, 16'h0, 4'd0);
    @(posedge clk); #1;
    reset_n = 1'b0; bus.start = 1'b1; bus.in = 16'h5555; bus.shift = 4'd3;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1; bus.start = 1'b0;
    @(negedge clk);
    chk("rst_out",  bus.out, 16'h0);
    chk("rst_busy", {15'h0, bus.busy}, 16'h0);
    chk("rst_done", {15'h0, bus.done}, 16'h0);
    chk("rst_zero", {15'h0, bus.zero}, 16'h1);

    // Start held high through SHIFT with changing operands; in the DONE cycle
    // request 1<<2, which must start with no idle bubble.
    drive(1'b1, 16'h0100, 4'd3);
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        bus.start = 1'b1; bus.in = 16'h0001; bus.shift = 4'd2;
        break;
      end
      bus.in = 16'($urandom); bus.shift = 4'($urandom_range(1, 15));
    end
    drive(1'b0, 16'h0, 4'd0);
    chk("b2b_busy", {15'h0, bus.busy}, 16'h1);
    wait_done("b2b");
    chk("b2b_out", bus.out, 16'h0004);

    // Randomized operations, occasionally back-to-back.
    for (int k = 0; k < 60; k++) begin
      logic [15:0] a;
      logic [3:0]  n;
      a = 16'($urandom);
      if (k % 4 == 0) a = {{8{a[15]}}, a[7:0]};
      n = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) != 0) repeat ($urandom_range(1, 2)) drive(1'b0, 16'h0, 4'd0);
      run_op("rand", a, n, 0, 16'h0, 0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
